// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver.
// Oversamples the PS/2 lines on a divided tick, deglitches the keyboard clock,
// frames 11-bit packets, folds E0/F0 prefixes into make/break events and
// queues them in a first-word-fall-through FIFO with a valid/ready handshake.
module ps2_scan_rx #(
    parameter int CLK_DIV    = 250,
    parameter int FILT_LEN   = 4,
    parameter int TIMEOUT    = 4000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       EV_READY,
    input  logic       CLR_OVF,
    output logic       EV_VALID,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_BREAK,
    output logic       FRAME_ERR,
    output logic       OVERFLOW
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RUN_W = $clog2(FILT_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int EV_W  = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Reset: asserts immediately, releases on a clock edge
    // ------------------------------------------------------------------
    logic rst_meta_reg;
    logic rst_n_int;

    // Two-flop reset release so every flop leaves reset on the same edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_meta_reg <= 1'b0;
            rst_n_int    <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_n_int    <= rst_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Input synchronisers (idle line level is 1)
    // ------------------------------------------------------------------
    logic clk_meta_reg, clk_sync_reg;
    logic dat_meta_reg, dat_sync_reg;

    // Bring the asynchronous keyboard lines into the CLK domain
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            clk_meta_reg <= 1'b1;
            clk_sync_reg <= 1'b1;
            dat_meta_reg <= 1'b1;
            dat_sync_reg <= 1'b1;
        end else begin
            clk_meta_reg <= PS2_CLK;
            clk_sync_reg <= clk_meta_reg;
            dat_meta_reg <= PS2_DATA;
            dat_sync_reg <= dat_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;

    assign tick = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

    // Free-running divider, one tick every CLK_DIV cycles
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Clock deglitch filter and bit strobe
    // ------------------------------------------------------------------
    logic             filt_clk_reg, filt_clk_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic             strobe;
    logic             bit_in;

    // Count consecutive ticks that disagree with the filtered level
    always_comb begin
        filt_clk_next = filt_clk_reg;
        run_next      = run_reg;
        if (tick) begin
            if (clk_sync_reg == filt_clk_reg) begin
                run_next = '0;
            end else if (run_reg == RUN_W'(FILT_LEN - 1)) begin
                filt_clk_next = clk_sync_reg;
                run_next      = '0;
            end else begin
                run_next = run_reg + 1'b1;
            end
        end
    end

    // Filter state register
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            filt_clk_reg <= 1'b1;
            run_reg      <= '0;
        end else begin
            filt_clk_reg <= filt_clk_next;
            run_reg      <= run_next;
        end
    end

    // A bit is taken on the tick where the filtered clock falls
    assign strobe = filt_clk_reg & ~filt_clk_next;
    assign bit_in = dat_sync_reg;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [3:0]      bit_cnt_reg, bit_cnt_next;
    logic [10:0]     shift_reg, shift_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            frame_ok;
    logic            timeout_hit;
    logic            frame_err_next, byte_stb_next;

    // Frame bits land LSB-first: [0]=start, [8:1]=data, [9]=parity, [10]=stop
    assign frame_ok    = ~shift_reg[0] & shift_reg[10] & (^shift_reg[9:1]);
    assign timeout_hit = (to_cnt_reg >= TO_W'(TIMEOUT));

    // State and frame datapath registers
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            to_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            to_cnt_reg  <= to_cnt_next;
        end
    end

    // Next-state logic: start detection, bit shifting, timeout abort
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        to_cnt_next  = to_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                to_cnt_next = '0;
                if (strobe && !bit_in) begin
                    state_next   = S_RECV;
                    bit_cnt_next = 4'd1;
                    shift_next   = {bit_in, shift_reg[10:1]};
                end
            end
            S_RECV: begin
                if (strobe) begin
                    shift_next   = {bit_in, shift_reg[10:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    to_cnt_next  = '0;
                    if (bit_cnt_reg == 4'd10) begin
                        state_next = S_CHECK;
                    end
                end else if (timeout_hit) begin
                    state_next  = S_IDLE;
                    to_cnt_next = '0;
                end else if (tick) begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            S_CHECK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: error on a bad frame or an abandoned one, byte on a good frame
    always_comb begin
        frame_err_next = 1'b0;
        byte_stb_next  = 1'b0;
        case (state_reg)
            S_RECV:  frame_err_next = ~strobe & timeout_hit;
            S_CHECK: begin
                frame_err_next = ~frame_ok;
                byte_stb_next  = frame_ok;
            end
            default: ;
        endcase
    end

    logic       frame_err_reg;
    logic       byte_stb_reg;
    logic [7:0] byte_reg;

    // Register the FSM outputs and capture the data byte while in CHECK
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            frame_err_reg <= 1'b0;
            byte_stb_reg  <= 1'b0;
            byte_reg      <= '0;
        end else begin
            frame_err_reg <= frame_err_next;
            byte_stb_reg  <= byte_stb_next;
            if (state_reg == S_CHECK) begin
                byte_reg <= shift_reg[8:1];
            end
        end
    end

    assign FRAME_ERR = frame_err_reg;

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    logic            ext_reg, brk_reg;
    logic            push;
    logic [EV_W-1:0] push_data;

    assign push      = byte_stb_reg && (byte_reg != 8'hE0) && (byte_reg != 8'hF0);
    assign push_data = {byte_reg, ext_reg, brk_reg};

    // Track E0/F0 prefixes; any other byte closes the event and clears them
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (frame_err_reg) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (byte_stb_reg) begin
            case (byte_reg)
                8'hE0:   ext_reg <= 1'b1;
                8'hF0:   brk_reg <= 1'b1;
                default: begin
                    ext_reg <= 1'b0;
                    brk_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first word fall through)
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             fifo_full, fifo_empty;
    logic             pop, wr_en, drop;
    logic [EV_W-1:0]  entry_rd [FIFO_DEPTH];
    logic [EV_W-1:0]  head;
    logic             ovf_reg;

    assign fifo_full  = (cnt_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (cnt_reg == '0);
    assign pop        = ~fifo_empty & EV_READY;
    assign wr_en      = push & (~fifo_full | pop);
    assign drop       = push & fifo_full & ~pop;

    // One storage word per FIFO slot
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [EV_W-1:0] entry_reg;

            // Slot written only when the write pointer selects it
            always_ff @(posedge CLK) begin
                if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_rd[gi] = entry_reg;
        end
    endgenerate

    assign head = entry_rd[rd_ptr_reg];

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (wr_en && !pop) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (!wr_en && pop) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ovf_reg <= 1'b0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
        end else if (CLR_OVF) begin
            ovf_reg <= 1'b0;
        end
    end

    assign OVERFLOW = ovf_reg;
    assign EV_VALID = ~fifo_empty;
    assign {EV_CODE, EV_EXT, EV_BREAK} = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: scoreboard bench for the PS/2 receiver. The stimulus side
// drives keyboard frames and feeds a byte-level event model; a monitor pops
// expected events whenever the receiver hands one over.
module tb_ps2_scan_rx;

    localparam int CLK_DIV  = 4;
    localparam int FILT_LEN = 2;
    localparam int TIMEOUT  = 64;
    localparam int DEPTH    = 8;
    localparam int HALF     = 40;   // PS/2 clock half period in CLK cycles

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       EV_READY = 1'b0;
    logic       CLR_OVF = 1'b0;
    logic       EV_VALID;
    logic [7:0] EV_CODE;
    logic       EV_EXT;
    logic       EV_BREAK;
    logic       FRAME_ERR;
    logic       OVERFLOW;

    ps2_scan_rx #(
        .CLK_DIV   (CLK_DIV),
        .FILT_LEN  (FILT_LEN),
        .TIMEOUT   (TIMEOUT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .EV_READY (EV_READY),
        .CLR_OVF  (CLR_OVF),
        .EV_VALID (EV_VALID),
        .EV_CODE  (EV_CODE),
        .EV_EXT   (EV_EXT),
        .EV_BREAK (EV_BREAK),
        .FRAME_ERR(FRAME_ERR),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected events {code, ext, brk}
    logic [9:0] exp_q[$];
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    int         exp_err = 0;
    int         seen_err = 0;
    bit         exp_ovf = 1'b0;
    int         rdy_mode = 0;    // 0: hold low, 1: hold high, 2: random
    int         lat = -1;
    bit         mon_en = 1'b1;

    function automatic void chk(string nm, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endfunction

    // Byte-level meaning of a received byte
    function automatic void model_byte(logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back({b, m_ext, m_brk});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void model_err();
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive nbits of an 11-bit frame; at the stop bit the model is updated
    task automatic send_bits(logic [10:0] fr, int nbits, bit bad);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = fr[i];
            step(HALF / 2);
            PS2_CLK = 1'b0;
            if (i == 10) begin
                if (bad) model_err();
                else model_byte(fr[8:1]);
                lat = -1;
                for (int c = 1; c <= HALF; c++) begin
                    step(1);
                    if (lat < 0 && EV_VALID) lat = c;
                end
            end else begin
                step(HALF);
            end
            PS2_CLK = 1'b1;
            step(HALF / 2);
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] b, bit bad);
        logic par;
        par = ~(^b) ^ bad;
        send_bits({1'b1, par, b, 1'b0}, 11, bad);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            step(1);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        step(20);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        chk("rst_valid", EV_VALID, 0);
        chk("rst_event", {EV_CODE, EV_EXT, EV_BREAK}, 0);
        chk("rst_frame_err", FRAME_ERR, 0);
        chk("rst_overflow", OVERFLOW, 0);
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_ovf = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        step(5);
        RST_N = 1'b1;
        step(10);
    endtask

    // Ready driver
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rdy_mode == 2) EV_READY = 1'($urandom_range(0, 1));
            else EV_READY = (rdy_mode == 1);
        end
    end

    // Monitor: scoreboard pops, frame error pulse width, empty-output check
    initial begin
        int fe_len = 0;
        logic [9:0] e;
        forever begin
            @(negedge CLK);
            if (RST_N && mon_en) begin
                if (FRAME_ERR) begin
                    fe_len++;
                end else if (fe_len > 0) begin
                    chk("frame_err_width", fe_len, 1);
                    seen_err++;
                    fe_len = 0;
                end
                if (!EV_VALID) begin
                    chk("empty_outputs", {EV_CODE, EV_EXT, EV_BREAK}, 0);
                end else if (EV_READY) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", {EV_CODE, EV_EXT, EV_BREAK}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event", {EV_CODE, EV_EXT, EV_BREAK}, e);
                    end
                end
            end else begin
                fe_len = 0;
            end
        end
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        #2;
        do_reset();

        // Single frame, held in the FIFO to check latency and head contents
        rdy_mode = 0;
        send_frame(8'h1C, 1'b0);
        chk("latency_window", int'(lat >= 9 && lat <= 12), 1);
        chk("head_valid", EV_VALID, 1);
        chk("head_code", EV_CODE, 8'h1C);
        rdy_mode = 1;
        wait_drain();
        chk("no_err_1c", seen_err, exp_err);

        // Prefix folding
        rdy_mode = 2;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'h6B, 1'b0);
        wait_drain();
        chk("err_prefix", seen_err, exp_err);

        // Parity error clears a pending prefix
        send_frame(8'hE0, 1'b0);
        send_frame(8'h16, 1'b1);
        step(20);
        chk("err_parity", seen_err, exp_err);
        send_frame(8'h16, 1'b0);
        wait_drain();

        // Timeout on a partial frame
        send_frame(8'hF0, 1'b0);
        send_bits({1'b1, ~(^8'h74), 8'h74, 1'b0}, 5, 1'b0);
        step((TIMEOUT + 50) * CLK_DIV * 4);
        model_err();
        chk("err_timeout", seen_err, exp_err);
        send_frame(8'h74, 1'b0);
        wait_drain();

        // One-tick clock glitch with data low must not start a frame
        PS2_DATA = 1'b0;
        PS2_CLK = 1'b0;
        step(CLK_DIV);
        PS2_CLK = 1'b1;
        step(HALF);
        PS2_DATA = 1'b1;
        step(HALF);
        send_frame(8'h1C, 1'b0);
        wait_drain();
        chk("err_glitch", seen_err, exp_err);

        // Overflow: nine events into an eight-entry FIFO with no consumer
        rdy_mode = 0;
        step(4);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hE0 || b == 8'hF0) b = 8'h2A;
            send_frame(b, 1'b0);
        end
        chk("ovf_set", OVERFLOW, int'(exp_ovf));
        chk("ovf_full_valid", EV_VALID, 1);
        rdy_mode = 1;
        wait_drain();
        chk("ovf_sticky", OVERFLOW, 1);
        CLR_OVF = 1'b1;
        step(1);
        CLR_OVF = 1'b0;
        step(1);
        chk("ovf_cleared", OVERFLOW, 0);
        exp_ovf = 1'b0;

        // Randomised traffic with prefixes and occasional parity errors
        rdy_mode = 2;
        for (int i = 0; i < 12; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            send_frame(b, r == 7);
        end
        send_frame(8'h5A, 1'b0);
        wait_drain();
        chk("err_random", seen_err, exp_err);

        // Reset in the middle of a frame with an event pending
        rdy_mode = 0;
        send_frame(8'h29, 1'b0);
        chk("pre_reset_valid", EV_VALID, 1);
        send_bits({1'b1, ~(^8'h33), 8'h33, 1'b0}, 5, 1'b0);
        mon_en = 1'b0;
        do_reset();
        mon_en = 1'b1;
        rdy_mode = 1;
        send_frame(8'h74, 1'b0);
        wait_drain();
        chk("post_reset_empty", EV_VALID, 0);
        chk("final_err", seen_err, exp_err);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
